// File: rtl/pipeline_ctrl.sv
// Hazard, flush and nested-interrupt sequencer around the EX stage.
// Drives pipeline enables/flushes, interrupt entry strobes and the priority-level stack.
module pipeline_ctrl #(
  parameter int          NIRQ       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            ex_memtoreg,
  input  logic [4:0]      ex_dst,
  input  logic [4:0]      id_ra,
  input  logic [4:0]      id_rb,
  input  logic            id_use_ra,
  input  logic            id_use_rb,
  input  logic            jump_rst,
  input  logic            ex_eret,
  input  logic [NIRQ-1:0] irq,
  input  logic            ie,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            int_enter,
  output logic [31:0]     int_vec,
  output logic [NIRQ-1:0] int_ack,
  output logic            epc_push,
  output logic            epc_pop,
  output logic [1:0]      cur_level,
  output logic [1:0]      depth,
  output logic [15:0]     stall_cnt
);

  // state     | meaning
  // RUN       | normal issue; hazards, redirects and irq acceptance evaluated
  // INT_FLUSH | one-cycle interrupt entry: PC loads int_vec, EPC pushed
  // HALTED    | pipeline frozen until halt drops
  typedef enum logic [1:0] {RUN, INT_FLUSH, HALTED} state_t;

  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  state_t        state, state_nxt;
  logic [IW-1:0] hi_idx, sel;
  logic          hi_any, lu, redirect, accept, stall;
  logic [1:0]    lvl_stack [NIRQ];

  always_comb begin
    hi_idx = '0;
    hi_any = 1'b0;
    for (int k = 0; k < NIRQ; k++) begin
      if (irq[k]) begin
        hi_idx = IW'(k);
        hi_any = 1'b1;
      end
    end
  end

  assign lu = ex_memtoreg && (ex_dst != 5'd0) &&
              ((id_use_ra && (id_ra == ex_dst)) || (id_use_rb && (id_rb == ex_dst)));
  assign redirect = jump_rst || ex_eret;

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    int_enter  = 1'b0;
    epc_push   = 1'b0;
    epc_pop    = 1'b0;
    int_ack    = '0;
    accept     = 1'b0;
    stall      = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          state_nxt  = HALTED;
        end else if (redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          epc_pop    = ex_eret && (depth != 2'd0) && rst_n;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall      = 1'b1;
        end else if (ie && hi_any && rst_n &&
                     ((32'(hi_idx) + 32'd1) > 32'(cur_level))) begin
          accept    = 1'b1;
          int_ack   = NIRQ'(1) << hi_idx;
          state_nxt = INT_FLUSH;
        end
      end
      // Entry always completes; a halt arriving now takes effect next cycle.
      INT_FLUSH: begin
        int_enter  = 1'b1;
        epc_push   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_nxt  = halt ? HALTED : RUN;
      end
      HALTED: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (!halt) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      sel       <= '0;
      int_vec   <= '0;
      cur_level <= '0;
      depth     <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < NIRQ; k++) lvl_stack[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel     <= hi_idx;
        int_vec <= VEC_BASE + VEC_STRIDE * 32'(hi_idx);
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (state == INT_FLUSH) begin
        lvl_stack[depth] <= cur_level;
        cur_level        <= 2'(sel) + 2'd1;
        depth            <= depth + 2'd1;
      end else if (epc_pop) begin
        cur_level <= lvl_stack[depth - 2'd1];
        depth     <= depth - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded bench for pipeline_ctrl: each stimulus step queues the outputs
// it must produce; a monitor pops and compares them mid-cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0, ex_memtoreg = 1'b0, id_use_ra = 1'b0, id_use_rb = 1'b0;
  logic [4:0]  ex_dst = '0, id_ra = '0, id_rb = '0;
  logic        jump_rst = 1'b0, ex_eret = 1'b0, ie = 1'b0;
  logic [2:0]  irq = '0;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, int_enter, epc_push, epc_pop;
  logic [31:0] int_vec;
  logic [2:0]  int_ack;
  logic [1:0]  cur_level, depth;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, int_enter, epc_push, epc_pop, int_ack[2:0]}
  localparam logic [9:0] C_RUN   = 10'b1100000000;
  localparam logic [9:0] C_STALL = 10'b0001000000;
  localparam logic [9:0] C_REDIR = 10'b1111000000;
  localparam logic [9:0] C_POP   = 10'b1111001000;
  localparam logic [9:0] C_ENTER = 10'b1111110000;

  typedef struct {
    string       tag;
    logic [9:0]  ctl;
    logic [1:0]  lvl;
    logic [1:0]  dep;
    logic [15:0] sc;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ex_memtoreg(ex_memtoreg), .ex_dst(ex_dst),
    .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .jump_rst(jump_rst), .ex_eret(ex_eret), .irq(irq), .ie(ie),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .int_enter(int_enter), .int_vec(int_vec), .int_ack(int_ack), .epc_push(epc_push),
    .epc_pop(epc_pop), .cur_level(cur_level), .depth(depth), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // lu_mode: 0 none, 1 hazard on ra, 2 hazard on rb, 3 load to r0, 4 ra match but unused
  task automatic step(input string tag, input logic h, input int lu_mode, input logic j,
                      input logic er, input logic [2:0] irqv, input logic iev,
                      input logic [9:0] ctl, input logic [1:0] lvl, input logic [1:0] dep,
                      input logic [15:0] sc, input logic [31:0] vec);
    exp_t e;
    @(negedge clk);
    halt = h; jump_rst = j; ex_eret = er; irq = irqv; ie = iev;
    ex_memtoreg = (lu_mode != 0);
    ex_dst      = (lu_mode == 3) ? 5'd0 : 5'd5;
    id_ra       = (lu_mode == 2) ? 5'd7 : ((lu_mode == 3) ? 5'd0 : 5'd5);
    id_rb       = (lu_mode == 2) ? 5'd5 : 5'd9;
    id_use_ra   = (lu_mode == 1) || (lu_mode == 3);
    id_use_rb   = (lu_mode == 2);
    e.tag = tag; e.ctl = ctl; e.lvl = lvl; e.dep = dep; e.sc = sc; e.vec = vec;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ctl"}, 32'({pc_en, ifid_en, ifid_flush, idex_flush, int_enter,
                                epc_push, epc_pop, int_ack}), 32'(e.ctl));
      chk({e.tag, ".lvl_dep"}, 32'({cur_level, depth}), 32'({e.lvl, e.dep}));
      chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
      chk({e.tag, ".int_vec"}, int_vec, e.vec);
    end
  end

  initial begin
    #1;
    chk("rst.lvl_dep", 32'({cur_level, depth}), 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst.int_vec", int_vec, 32'd0);
    chk("rst.int_ack", 32'(int_ack), 32'd0);
    #20 rst_n = 1'b1;

    //    tag            h  lu j  er irq     ie ctl            lvl dep sc  vec
    step("idle",         0, 0, 0, 0, 3'b000, 0, C_RUN,          0, 0, 0, 32'h0);
    step("lu_ra",        0, 1, 0, 0, 3'b000, 0, C_STALL,        0, 0, 0, 32'h0);
    step("after_lu",     0, 0, 0, 0, 3'b000, 0, C_RUN,          0, 0, 1, 32'h0);
    step("lu_rb",        0, 2, 0, 0, 3'b000, 0, C_STALL,        0, 0, 1, 32'h0);
    step("dst_r0",       0, 3, 0, 0, 3'b000, 0, C_RUN,          0, 0, 2, 32'h0);
    step("unused_src",   0, 4, 0, 0, 3'b000, 0, C_RUN,          0, 0, 2, 32'h0);
    step("redir_lu",     0, 1, 1, 0, 3'b000, 0, C_REDIR,        0, 0, 2, 32'h0);
    step("eret_d0",      0, 0, 0, 1, 3'b000, 0, C_REDIR,        0, 0, 2, 32'h0);
    step("masked",       0, 0, 0, 0, 3'b111, 0, C_RUN,          0, 0, 2, 32'h0);
    step("acc0",         0, 0, 0, 0, 3'b001, 1, C_RUN | 10'd1,  0, 0, 2, 32'h0);
    step("ent0",         0, 0, 0, 0, 3'b001, 1, C_ENTER,        0, 0, 2, 32'h1000);
    step("in0_same",     0, 0, 0, 0, 3'b001, 1, C_RUN,          1, 1, 2, 32'h1000);
    step("acc2",         0, 0, 0, 0, 3'b101, 1, C_RUN | 10'd4,  1, 1, 2, 32'h1000);
    step("ent2",         0, 0, 0, 0, 3'b000, 1, C_ENTER,        1, 1, 2, 32'h1020);
    step("in2_lower",    0, 0, 0, 0, 3'b010, 1, C_RUN,          3, 2, 2, 32'h1020);
    step("eret_l3",      0, 0, 0, 1, 3'b000, 1, C_POP,          3, 2, 2, 32'h1020);
    step("after_pop",    0, 0, 0, 0, 3'b000, 1, C_RUN,          1, 1, 2, 32'h1020);
    step("acc1",         0, 0, 0, 0, 3'b010, 1, C_RUN | 10'd2,  1, 1, 2, 32'h1020);
    step("ent1_halt",    1, 0, 0, 0, 3'b000, 1, C_ENTER,        1, 1, 2, 32'h1010);
    step("halted_irq",   1, 0, 0, 0, 3'b100, 1, C_STALL,        2, 2, 2, 32'h1010);
    step("halt_rel",     0, 0, 0, 0, 3'b000, 1, C_STALL,        2, 2, 2, 32'h1010);
    step("resume",       0, 0, 0, 0, 3'b000, 1, C_RUN,          2, 2, 2, 32'h1010);
    step("halt_run",     1, 1, 1, 0, 3'b000, 1, C_STALL,        2, 2, 2, 32'h1010);
    step("halted_redir", 1, 1, 1, 0, 3'b000, 1, C_STALL,        2, 2, 2, 32'h1010);
    step("halted_last",  0, 0, 0, 0, 3'b000, 1, C_STALL,        2, 2, 2, 32'h1010);
    step("run2",         0, 0, 0, 0, 3'b000, 1, C_RUN,          2, 2, 2, 32'h1010);
    step("eret_l2",      0, 0, 0, 1, 3'b000, 1, C_POP,          2, 2, 2, 32'h1010);
    step("eret_l1",      0, 0, 0, 1, 3'b000, 1, C_POP,          1, 1, 2, 32'h1010);
    step("unnested",     0, 0, 0, 0, 3'b000, 1, C_RUN,          0, 0, 2, 32'h1010);
    step("redir_irq",    0, 0, 1, 0, 3'b100, 1, C_REDIR,        0, 0, 2, 32'h1010);
    step("lu_irq",       0, 1, 0, 0, 3'b100, 1, C_STALL,        0, 0, 2, 32'h1010);
    step("acc2b",        0, 0, 0, 0, 3'b100, 1, C_RUN | 10'd4,  0, 0, 3, 32'h1010);
    step("ent2b",        0, 0, 0, 0, 3'b000, 1, C_ENTER,        0, 0, 3, 32'h1020);
    step("pre_rst",      0, 0, 0, 0, 3'b000, 1, C_RUN,          3, 1, 3, 32'h1020);

    @(negedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("midnest_rst.lvl_dep", 32'({cur_level, depth}), 32'd0);
    chk("midnest_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("midnest_rst.int_vec", int_vec, 32'd0);
    chk("midnest_rst.pulses", 32'({int_enter, epc_push, epc_pop, int_ack}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",     0, 0, 0, 0, 3'b000, 1, C_RUN,          0, 0, 0, 32'h0);
    @(negedge clk);
    #4;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
